// File: rtl/oob_regfile.sv
// Register file with bounds-checked word/bit writes and reads, OOB flags and sticky error status.
// Optional saturating OOB event counter is built when OOB_REGFILE_ERRCNT_EN is defined.
module oob_regfile #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 6,
  parameter int unsigned IDXW  = 3,
  parameter int unsigned BIDXW = 3,
  parameter int unsigned CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_bit,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [BIDXW-1:0] wr_bidx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_oob,
  output logic             wr_oob,
  output logic             oob_sticky,
  input  logic             err_clr,
  output logic [CNTW-1:0]  err_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_idx_ok;
  logic wr_bidx_ok;
  logic rd_idx_ok;
  logic wr_oob_ev;
  logic rd_oob_ev;

  // Bounds decode; a bit write is only in range when both indices are
  always_comb begin
    wr_idx_ok  = 32'(wr_idx) < DEPTH;
    wr_bidx_ok = 32'(wr_bidx) < WIDTH;
    rd_idx_ok  = 32'(rd_idx) < DEPTH;
    wr_oob_ev  = wr_en && (!wr_idx_ok || (wr_bit && !wr_bidx_ok));
    rd_oob_ev  = rd_en && !rd_idx_ok;
  end

  // Storage update; out-of-range writes fall through untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (wr_en && wr_idx_ok) begin
      if (!wr_bit) begin
        mem[wr_idx] <= wr_data;
      end else if (wr_bidx_ok) begin
        mem[wr_idx][wr_bidx] <= wr_data[0];
      end
    end
  end

  // Read port samples storage before this edge's write lands
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_oob   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_oob  <= !rd_idx_ok;
        rd_data <= rd_idx_ok ? mem[rd_idx] : '0;
      end
    end
  end

  // Drop pulse and sticky status; clear takes priority over a same-edge event
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_oob     <= 1'b0;
      oob_sticky <= 1'b0;
    end else begin
      wr_oob <= wr_oob_ev;
      if (err_clr) begin
        oob_sticky <= 1'b0;
      end else if (wr_oob_ev || rd_oob_ev) begin
        oob_sticky <= 1'b1;
      end
    end
  end

`ifdef OOB_REGFILE_ERRCNT_EN
  localparam int unsigned SUMW = CNTW + 1;

  logic [CNTW-1:0] cnt_q;
  logic [1:0]      ev_num;
  logic [SUMW-1:0] cnt_sum;

  // A read and a write OOB at the same edge add two events
  always_comb begin
    ev_num  = {1'b0, wr_oob_ev} + {1'b0, rd_oob_ev};
    cnt_sum = {1'b0, cnt_q} + SUMW'(ev_num);
  end

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      cnt_q <= '0;
    end else if (cnt_sum[CNTW]) begin
      cnt_q <= '1;
    end else begin
      cnt_q <= cnt_sum[CNTW-1:0];
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: doc/oob_regfile.md
OOB_REGFILE -- requirements
Module: oob_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7, giving the entry width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 6, giving the number of entries; DEPTH need not be a power of two.
REQ-003 The block SHALL have parameter IDXW, default 3, giving the entry index width; 2**IDXW >= DEPTH.
REQ-004 The block SHALL have parameter BIDXW, default 3, giving the bit index width; 2**BIDXW >= WIDTH.
REQ-005 The block SHALL have parameter CNTW, default 8, giving the error counter width.
REQ-006 The block SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have ports wr_en (input, 1 bit, write request) and wr_bit (input, 1 bit, 1 = single-bit write, 0 = whole-word write).
REQ-009 The block SHALL have ports wr_idx (input, IDXW), wr_bidx (input, BIDXW) and wr_data (input, WIDTH); wr_bidx and wr_data[0] are used only for bit writes.
REQ-010 The block SHALL have ports rd_en (input, 1 bit) and rd_idx (input, IDXW) as the read request.
REQ-011 The block SHALL have ports rd_data (output, WIDTH), rd_valid (output, 1 bit) and rd_oob (output, 1 bit) as the read response.
REQ-012 The block SHALL have ports wr_oob (output, 1 bit, per-write drop pulse), oob_sticky (output, 1 bit), err_clr (input, 1 bit) and err_cnt (output, CNTW).

Function
REQ-013 A word write SHALL store wr_data in entry wr_idx at the clock edge when wr_en=1, wr_bit=0 and wr_idx<DEPTH.
REQ-014 A bit write SHALL set bit wr_bidx of entry wr_idx to wr_data[0] when wr_en=1, wr_bit=1, wr_idx<DEPTH and wr_bidx<WIDTH; all other bits are unchanged.
REQ-015 Out-of-bounds writes (wr_idx>=DEPTH, or a bit write with wr_bidx>=WIDTH) SHALL modify no storage, and wr_oob SHALL be 1 in the following cycle only.
REQ-016 A read SHALL have 1-cycle latency: rd_en=1 at edge N gives rd_valid=1 after edge N, with rd_data holding entry rd_idx and rd_oob=0.
REQ-017 A read with rd_idx>=DEPTH SHALL return rd_data=0 and rd_oob=1, with rd_valid=1.
REQ-018 When rd_en=0, rd_valid SHALL be 0 and rd_data and rd_oob SHALL hold their last values.
REQ-019 A read and a write to the same entry at the same edge SHALL return the pre-write contents (read-before-write).
REQ-020 Any OOB read or OOB write SHALL set oob_sticky, which stays set until err_clr or rst.
REQ-021 err_clr=1 SHALL clear oob_sticky and err_cnt at the edge; an OOB event at the same edge is lost, and clear wins.
REQ-022 An OOB read and an OOB write at the same edge SHALL count as 2 events.

Reset
REQ-023 While rst=1 at an edge, all entries, rd_data, rd_valid, rd_oob, wr_oob, oob_sticky and err_cnt SHALL become 0, and any concurrent read or write SHALL be ignored.
REQ-024 The first edge with rst=0 SHALL accept requests normally, and reset applied mid-operation SHALL discard any pending read response.

Configuration
REQ-025 With macro OOB_REGFILE_ERRCNT_EN defined, err_cnt SHALL count OOB events, saturating at 2**CNTW-1.
REQ-026 Without OOB_REGFILE_ERRCNT_EN, err_cnt SHALL be constant 0 and no counter logic is built; oob_sticky is unaffected.

Verification
REQ-027 Word write 7'h55 to idx 0, then a word write to idx 6 (OOB) with 7'h7F, then read idx 0 -> rd_data=7'h55, wr_oob pulses once, rd_oob=0.
REQ-028 Fill entries 0..5 with the index value, then read idx 0..7 -> entries 0..5 return 0..5; entries 6 and 7 return 0 with rd_oob=1, and rd_valid is 1 each cycle.
REQ-029 Word write 0, then bit writes to bidx 6 and 7 with data 1 -> entry reads 7'h40; the bidx 7 write raises wr_oob.
REQ-030 Same-edge read and write of idx 2, old value 3, new value 9 -> read returns 3; the next read returns 9.
REQ-031 With OOB_REGFILE_ERRCNT_EN and CNTW=2: 5 OOB writes -> err_cnt=3 (saturated) and oob_sticky=1; err_clr with a concurrent OOB write -> both 0.
REQ-032 Assert rst the cycle after a read request -> rd_valid=0, and all entries read 0 afterwards.
